// File: rtl/inst_fetch_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, redirect, and
// the downstream instruction handshake.
interface inst_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc,
    output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, inst_ready
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch front end: PC, credit-limited memory requests, in-order
// instruction buffer with registered head, and redirect flush.
module inst_fetch #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input logic          clk,
  input logic          rst,
  inst_fetch_if.master bus
);
  localparam int unsigned FAW = $clog2(FIFO_DEPTH);
  localparam int unsigned FCW = FAW + 1;
  localparam int unsigned QAW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned OCW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t          state, state_n;
  logic [31:0]     pc, pc_n;
  logic            req, req_n;
  logic [OCW-1:0]  out_cnt, out_n;
  logic [OCW-1:0]  disc_cnt, disc_n;
  logic [FCW-1:0]  fifo_cnt, cnt_n;
  logic [FAW-1:0]  f_rd, f_rd_n, f_wr, f_wr_n;
  logic [QAW-1:0]  q_rd, q_rd_n, q_wr, q_wr_n;
  logic            valid_q, valid_n;
  logic [31:0]     inst_q, inst_n, ipc_q, ipc_n;
  logic            hs, rsp, push, pop;

  logic [31:0]     fifo_data [FIFO_DEPTH];
  logic [31:0]     fifo_pc   [FIFO_DEPTH];
  logic [31:0]     flight_pc [MAX_OUTSTANDING];

  function automatic logic [QAW-1:0] q_inc(input logic [QAW-1:0] p);
    return (32'(p) == MAX_OUTSTANDING - 1) ? '0 : p + QAW'(1);
  endfunction

  // Next-state: handshake, response accounting, buffer, redirect flush, credit
  always_comb begin
    state_n  = state;
    pc_n     = pc;
    out_n    = out_cnt;
    disc_n   = disc_cnt;
    cnt_n    = fifo_cnt;
    f_rd_n   = f_rd;
    f_wr_n   = f_wr;
    q_rd_n   = q_rd;
    q_wr_n   = q_wr;
    valid_n  = valid_q;
    inst_n   = inst_q;
    ipc_n    = ipc_q;
    req_n    = 1'b0;

    hs   = req && bus.imem_gnt;
    rsp  = bus.imem_rvalid && (out_cnt != '0);
    push = rsp && (disc_cnt == '0) && !bus.redirect;
    pop  = valid_q && bus.inst_ready;

    if (hs) begin
      pc_n   = pc + 32'd4;
      q_wr_n = q_inc(q_wr);
    end
    if (rsp) q_rd_n = q_inc(q_rd);
    out_n = out_cnt + OCW'(hs) - OCW'(rsp);
    if (rsp && (disc_cnt != '0)) disc_n = disc_cnt - OCW'(1);

    if (push) f_wr_n = f_wr + FAW'(1);
    if (pop)  f_rd_n = f_rd + FAW'(1);
    cnt_n = fifo_cnt + FCW'(push) - FCW'(pop);

    case (state)
      RUN:     state_n = RUN;
      FLUSH:   if (disc_n == '0) state_n = RUN;
      default: state_n = RUN;
    endcase

    // Everything still in flight at the end of this cycle becomes stale
    if (bus.redirect) begin
      state_n = FLUSH;
      pc_n    = bus.redirect_pc & ~32'h3;
      disc_n  = out_n;
      cnt_n   = '0;
      f_rd_n  = '0;
      f_wr_n  = '0;
    end

    valid_n = (cnt_n != '0);
    if (cnt_n != '0) begin
      if (push && (f_wr == f_rd_n)) begin
        inst_n = bus.imem_rdata;
        ipc_n  = flight_pc[q_rd];
      end else begin
        inst_n = fifo_data[f_rd_n];
        ipc_n  = fifo_pc[f_rd_n];
      end
    end

    // Credit: live requests plus buffered words can never exceed the buffer
    req_n = (32'(out_n) < MAX_OUTSTANDING) &&
            ((32'(out_n) - 32'(disc_n) + 32'(cnt_n)) < FIFO_DEPTH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      pc       <= RESET_PC;
      req      <= 1'b0;
      out_cnt  <= '0;
      disc_cnt <= '0;
      fifo_cnt <= '0;
      f_rd     <= '0;
      f_wr     <= '0;
      q_rd     <= '0;
      q_wr     <= '0;
      valid_q  <= 1'b0;
      inst_q   <= '0;
      ipc_q    <= '0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      req      <= req_n;
      out_cnt  <= out_n;
      disc_cnt <= disc_n;
      fifo_cnt <= cnt_n;
      f_rd     <= f_rd_n;
      f_wr     <= f_wr_n;
      q_rd     <= q_rd_n;
      q_wr     <= q_wr_n;
      valid_q  <= valid_n;
      inst_q   <= inst_n;
      ipc_q    <= ipc_n;
    end
  end

  // Buffer and in-flight pc storage; gated by handshake/response so no reset needed
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[f_wr] <= bus.imem_rdata;
      fifo_pc[f_wr]   <= flight_pc[q_rd];
    end
    if (hs) flight_pc[q_wr] <= pc;
  end

  assign bus.imem_req   = req;
  assign bus.imem_addr  = pc;
  assign bus.inst_valid = valid_q;
  assign bus.inst       = inst_q;
  assign bus.inst_pc    = ipc_q;
endmodule
